// File: rtl/cpu_uart_pkg.sv
// Shared definitions for the CPU UART receiver and result transmitter.
// Byte-level FSM states and frame layout constants.
package cpu_uart_pkg;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    localparam int         FRAME_BYTES    = 9;
    localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_tx_byte.sv
// Single-byte UART serialiser: start, 8 data bits LSB first, stop bits.
// Ready on the last stop-bit cycle so bytes can stream with no gap.
module uart_tx_byte
    import cpu_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int STOP_BITS    = 1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_valid,
    input  logic [7:0] i_data,
    output logic       o_ready,
    output logic       o_tx
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
    localparam logic SB_LAST = 1'(STOP_BITS - 1);

    tx_state_t     state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic          stop_idx;
    logic [7:0]    shreg;
    logic          bit_end;
    logic          last_stop;

    assign bit_end   = (cnt == CNT_MAX);
    assign last_stop = (state == TX_STOP) && bit_end && (stop_idx == SB_LAST);
    assign o_ready   = (state == TX_IDLE) || last_stop;

    // Bit-timing FSM; the line level is registered alongside the state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= TX_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            shreg    <= '0;
            o_tx     <= 1'b1;
        end else begin
            unique case (state)
                TX_IDLE: begin
                    cnt <= '0;
                    if (i_valid) begin
                        shreg <= i_data;
                        o_tx  <= 1'b0;
                        state <= TX_START;
                    end else begin
                        o_tx <= 1'b1;
                    end
                end
                TX_START: begin
                    if (bit_end) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        o_tx    <= shreg[0];
                        state   <= TX_DATA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                TX_DATA: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            stop_idx <= 1'b0;
                            o_tx     <= 1'b1;
                            state    <= TX_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shreg   <= {1'b0, shreg[7:1]};
                            o_tx    <= shreg[1];
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                TX_STOP: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (stop_idx == SB_LAST) begin
                            if (i_valid) begin
                                shreg <= i_data;
                                o_tx  <= 1'b0;
                                state <= TX_START;
                            end else begin
                                o_tx  <= 1'b1;
                                state <= TX_IDLE;
                            end
                        end else begin
                            stop_idx <= stop_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_result_tx.sv
// Snapshots CPU state on request and sends it as a 9-byte UART frame:
// header, pc, opcode, result bytes, flags, XOR checksum of bytes 1..7.
module uart_result_tx
    import cpu_uart_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 868,
    parameter int         STOP_BITS    = 1,
    parameter logic [7:0] HEADER       = HEADER_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_send,
    input  logic [7:0]  i_pc,
    input  logic [7:0]  i_opcode,
    input  logic [15:0] i_result_low,
    input  logic [15:0] i_result_high,
    input  logic [4:0]  i_flags,
    output logic        o_tx,
    output logic        o_busy,
    output logic        o_done
);

    localparam logic [3:0] N_BYTES = 4'(FRAME_BYTES);

    logic [7:0]  snap_pc;
    logic [7:0]  snap_op;
    logic [15:0] snap_lo;
    logic [15:0] snap_hi;
    logic [4:0]  snap_flags;
    logic [7:0]  chk;
    logic [3:0]  idx;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        byte_ready;
    logic        hs;
    logic        frame_end;
    logic        accept;

    assign byte_valid = o_busy && (idx < N_BYTES);
    assign hs         = byte_valid && byte_ready;
    assign frame_end  = o_busy && (idx == N_BYTES) && byte_ready;
    assign accept     = i_send && (!o_busy || frame_end);

    // Select the frame byte for the current index.
    always_comb begin
        byte_data = 8'hFF;
        unique case (idx)
            4'd0: byte_data = HEADER;
            4'd1: byte_data = snap_pc;
            4'd2: byte_data = snap_op;
            4'd3: byte_data = snap_lo[15:8];
            4'd4: byte_data = snap_lo[7:0];
            4'd5: byte_data = snap_hi[15:8];
            4'd6: byte_data = snap_hi[7:0];
            4'd7: byte_data = {3'b000, snap_flags};
            4'd8: byte_data = chk;
            default: byte_data = 8'hFF;
        endcase
    end

    // Frame sequencer: snapshot, byte index, checksum and done pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            snap_pc    <= '0;
            snap_op    <= '0;
            snap_lo    <= '0;
            snap_hi    <= '0;
            snap_flags <= '0;
            chk        <= '0;
            idx        <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
        end else begin
            o_done <= frame_end;
            if (accept) begin
                snap_pc    <= i_pc;
                snap_op    <= i_opcode;
                snap_lo    <= i_result_low;
                snap_hi    <= i_result_high;
                snap_flags <= i_flags;
                chk        <= '0;
                idx        <= '0;
                o_busy     <= 1'b1;
            end else if (frame_end) begin
                o_busy <= 1'b0;
            end else if (hs) begin
                idx <= idx + 4'd1;
                if (idx != 4'd0 && idx != 4'd8) begin
                    chk <= chk ^ byte_data;
                end
            end
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .STOP_BITS   (STOP_BITS)
    ) u_byte (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_valid(byte_valid),
        .i_data (byte_data),
        .o_ready(byte_ready),
        .o_tx   (o_tx)
    );

endmodule
